alu_seq_w: RTL and testbench
============================

// Module: alu_seq_w
// PURPOSE
//  Parametrised, handshaked successor to the 3-bit lab ALU. Takes WIDTH-bit operands
//  via valid/ready and returns a registered result with flags. Adds a multi-cycle
//  shift-add multiply, shifts, and tick-driven WIDTH-bit counter and LFSR sources.
//  Sits between the board switch/debounce front end and the LED/7-seg display driver.
// PARAMETERS
//  WIDTH      8           operand/result width, >=4
//  TICK_DIV   25_000_000  clk_50MHz cycles per counter/LFSR step tick, >=1
//  LFSR_TAPS  8'hB8       feedback mask, WIDTH bits; fb = ^(lfsr & LFSR_TAPS)
//  LFSR_SEED  1           reset value of LFSR; a zero seed is forced to 1
// PORTS
//  clk_50MHz  in   1        system clock
//  reset_n    in   1        asynchronous active-low reset
//  in_valid   in   1        operand/opcode valid
//  in_ready   out  1        block can accept an operation this cycle
//  A          in   WIDTH    operand A
//  B          in   WIDTH    operand B (shift ops use B[$clog2(WIDTH)-1:0])
//  ALU_Sel    in   4        opcode; also selects counter/LFSR stepping (below)
//  out_valid  out  1        result registers hold a valid result
//  out_ready  in   1        downstream consumes the result
//  ALU_Out    out  WIDTH    result (low half for MUL)
//  ALU_Out_Hi out  WIDTH    MUL high half; 0 for every other op
//  CarryOut   out  1        ADD carry / SUB borrow (A<B unsigned); 0 otherwise
//  Overflow   out  1        signed overflow for ADD/SUB; 0 otherwise
//  Zero       out  1        {ALU_Out_Hi,ALU_Out}==0
//  IllegalOp  out  1        opcode 11..15 accepted; result 0
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; state IDLE; counter=0; lfsr=LFSR_SEED
//   (1 if seed 0); tick divider=0. Reset mid-MUL aborts; no result emitted.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 read counter, 7 read LFSR,
//   8 MUL unsigned (2*WIDTH product), 9 SHL A by B, 10 SHR logical A by B; 11-15 illegal.
//  ADD/SUB: WIDTH-bit modular result; flags computed on WIDTH+1-bit sum/difference.
//  Handshake: transfer on in_valid&&in_ready; result transfer on out_valid&&out_ready.
//   in_ready = (state==IDLE) && (!out_valid || out_ready). While out_valid&&!out_ready
//   all result outputs hold stable. in_valid without in_ready is ignored (no capture).
//  FSM: IDLE -> (accept, op!=8) result registered, out_valid next edge (latency 1);
//   back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
//   IDLE -> (accept, op==8) MUL: latch A,B, clear acc, iteration count=0.
//   MUL: one shift-add per cycle, WIDTH cycles; in_ready=0 throughout; then
//   DONE: load outputs, out_valid set; latency WIDTH+1 from accept edge. -> IDLE.
//   DONE never stalls: entry to DONE requires output register empty or being consumed;
//   otherwise MUL holds its final iteration state until it is.
//  Tick: divider counts 0..TICK_DIV-1, 1-cycle tick pulse at wrap.
//  Counter steps +1 on tick while the live ALU_Sel==6 (independent of in_valid);
//   wraps 2^WIDTH-1 -> 0. LFSR steps {lfsr[W-2:0],fb} on tick while ALU_Sel==7.
//   Op 6/7 return the value registered at the accept edge (pre-step if same-cycle tick).
//  Shift amount >= WIDTH (possible for non-power-of-2 WIDTH) yields 0.
// CONFIGURATION
//  SAT_ARITH_EN defined: ADD clamps to all-ones on carry, SUB clamps to 0 on borrow;
//   CarryOut/Overflow still report the unsaturated condition; MUL unaffected.
//  SAT_ARITH_EN undefined: ADD/SUB wrap modulo 2^WIDTH (default).
// TESTING  (WIDTH=8, TICK_DIV=2 unless noted)
//  ADD A=F0 B=20 -> ALU_Out=10, CarryOut=1, Overflow=0, Zero=0, out_valid 1 cycle later.
//  SUB A=05 B=07 -> ALU_Out=FE, CarryOut=1; with SAT_ARITH_EN -> ALU_Out=00, CarryOut=1.
//  MUL A=0F B=11 -> {Hi,Out}=00FF at accept+9; in_ready=0 for cycles 1..9; hold
//   out_ready=0 5 cycles -> outputs stable, next op not accepted until drain.
//  ALU_Sel=7 held, reads after each tick -> LFSR 01,02,04,08,11; reset_n low -> 01.
//  ALU_Sel=6 held 512 cycles -> counter wraps FF->00; op 12 -> IllegalOp=1, Out=00.
//  reset_n low during MUL iteration 4 -> out_valid=0, in_ready=1 after release, no result.

Source files
------------

// File: rtl/alu_seq_w.sv
// alu_seq_w: handshaked WIDTH-bit ALU with multi-cycle shift-add multiply,
// shifts, and tick-driven counter / LFSR sources.
//
// Ports:
//   clk_50MHz, reset_n (async, active-low)
//   in_valid/in_ready  : operation handshake (A, B, ALU_Sel)
//   out_valid/out_ready: result handshake (ALU_Out, ALU_Out_Hi, flags)
//   ALU_Out            : result (low half for MUL)
//   ALU_Out_Hi         : MUL high half, 0 for other ops
//   CarryOut/Overflow  : ADD carry / SUB borrow, signed overflow
//   Zero               : {ALU_Out_Hi,ALU_Out} == 0
//   IllegalOp          : opcode 11..15 accepted
//
// Build option: define SAT_ARITH_EN to saturate ADD/SUB results; flags still
// report the unsaturated carry/borrow/overflow.
module alu_seq_w #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           TICK_DIV  = 25_000_000,
  parameter logic [WIDTH-1:0]      LFSR_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0]      LFSR_SEED = WIDTH'(1)
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Out_Hi,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             IllegalOp
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

`ifdef SAT_ARITH_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_CNT = 4'd6, OP_LFSR = 4'd7,
    OP_MUL = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10
  } op_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        iter_q, iter_d;
  logic [DW-1:0]        div_q, div_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d, lfsr_q, lfsr_d;
  logic                 ov_q, ov_d;
  logic [WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d;
  logic                 c_q, c_d, v_q, v_d, z_q, z_d, ill_q, ill_d;

  logic                 tick, out_free, accept;
  logic [WIDTH:0]       sum, diff;
  logic [SW-1:0]        shamt;
  logic                 shift_big;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_c, r_v, r_ill;

  assign out_free = !ov_q || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Tick divider and the counter / LFSR sources it steps.
  always_comb begin
    tick   = (div_q == DW'(TICK_DIV - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (tick && ALU_Sel == OP_CNT)  cnt_d  = cnt_q + 1'b1;
    if (tick && ALU_Sel == OP_LFSR) lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Single-cycle datapath.
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    diff      = {1'b0, A} - {1'b0, B};
    shamt     = B[SW-1:0];
    shift_big = (32'(shamt) >= WIDTH);
    r_lo      = '0;
    r_c       = 1'b0;
    r_v       = 1'b0;
    r_ill     = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        r_lo = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        r_c  = sum[WIDTH];
        r_v  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r_lo = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        r_c  = diff[WIDTH];
        r_v  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  r_lo = A & B;
      OP_OR:   r_lo = A | B;
      OP_XOR:  r_lo = A ^ B;
      OP_NOT:  r_lo = ~A;
      OP_CNT:  r_lo = cnt_q;
      OP_LFSR: r_lo = lfsr_q;
      OP_MUL:  r_lo = '0;
      OP_SHL:  r_lo = shift_big ? '0 : A << shamt;
      OP_SHR:  r_lo = shift_big ? '0 : A >> shamt;
      default: r_ill = 1'b1;
    endcase
  end

  // FSM, multiplier and result register next-state.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    ov_d     = ov_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    c_d      = c_q;
    v_d      = v_q;
    z_d      = z_q;
    ill_d    = ill_q;

    if (ov_q && out_ready) ov_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ALU_Sel == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            iter_d   = '0;
            state_d  = S_MUL;
          end else begin
            ov_d  = 1'b1;
            lo_d  = r_lo;
            hi_d  = '0;
            c_d   = r_c;
            v_d   = r_v;
            z_d   = (r_lo == '0);
            ill_d = r_ill;
          end
        end
      end
      S_MUL: begin
        if (iter_q != CW'(WIDTH)) begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          iter_d   = iter_q + 1'b1;
        end
        // Leave on the last iteration only if the output register will be
        // free for the DONE load; otherwise park with the finished product.
        if (iter_q >= CW'(WIDTH - 1) && out_free) state_d = S_DONE;
      end
      S_DONE: begin
        ov_d    = 1'b1;
        lo_d    = acc_q[WIDTH-1:0];
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        c_d     = 1'b0;
        v_d     = 1'b0;
        z_d     = (acc_q == '0);
        ill_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      ov_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      ov_q     <= ov_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= z_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid  = ov_q;
  assign ALU_Out    = lo_q;
  assign ALU_Out_Hi = hi_q;
  assign CarryOut   = c_q;
  assign Overflow   = v_q;
  assign Zero       = z_q;
  assign IllegalOp  = ill_q;

endmodule

// File: tb/tb_alu_seq_w.sv
// Self-checking bench for alu_seq_w (WIDTH=8, TICK_DIV=2).
module tb_alu_seq_w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [3:0] sel = '0;
  logic       in_ready, out_valid, CarryOut, Overflow, Zero, IllegalOp;
  logic [7:0] ALU_Out, ALU_Out_Hi;

  int errors = 0;
  int checks = 0;

  // Reference state for the tick-driven sources.
  int m_div, m_cnt, m_lfsr;

  always #5 clk = ~clk;

  alu_seq_w #(
    .WIDTH(8), .TICK_DIV(2), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)
  ) dut (
    .clk_50MHz(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .ALU_Out_Hi(ALU_Out_Hi), .CarryOut(CarryOut),
    .Overflow(Overflow), .Zero(Zero), .IllegalOp(IllegalOp)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = 0; m_cnt = 0; m_lfsr = 1;
    end else if (m_div == 1) begin
      m_div = 0;
      if (sel == 4'd6) m_cnt = (m_cnt + 1) % 256;
      if (sel == 4'd7) m_lfsr = ((m_lfsr * 2) % 256) + ($countones(m_lfsr & 'hB8) % 2);
    end else begin
      m_div = m_div + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({ALU_Out_Hi, ALU_Out, CarryOut, Overflow, Zero, IllegalOp});
  endfunction

  // Packs {hi, lo, carry, overflow, zero, illegal} from plain arithmetic.
  function automatic logic [31:0] ref_res(input int op, input int a, input int b,
                                          input int cnt, input int lf);
    int lo, hi, c, v, il, sa, sb, amt, p;
    logic [7:0] l8, h8;
    logic z;
    lo = 0; hi = 0; c = 0; v = 0; il = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    amt = b % 8;
    case (op)
      0: begin
        lo = (a + b) % 256; c = (a + b > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
`ifdef SAT_ARITH_EN
        if (c != 0) lo = 255;
`endif
      end
      1: begin
        lo = (a - b + 256) % 256; c = (a < b);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
`ifdef SAT_ARITH_EN
        if (c != 0) lo = 0;
`endif
      end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
      5: lo = 255 - a;
      6: lo = cnt;
      7: lo = lf;
      8: begin p = a * b; lo = p % 256; hi = p / 256; end
      9: lo = (a * (1 << amt)) % 256;
      10: lo = a / (1 << amt);
      default: il = 1;
    endcase
    l8 = lo[7:0];
    h8 = hi[7:0];
    z = (lo == 0) && (hi == 0);
    return 32'({h8, l8, c[0], v[0], z, il[0]});
  endfunction

  // Issue one op at a negedge with out_ready=1 and check its result.
  task automatic do_op(input int op, input int a, input int b);
    logic [31:0] e;
    int n;
    e = ref_res(op, a, b, m_cnt, m_lfsr);
    A = a[7:0]; B = b[7:0]; sel = op[3:0]; in_valid = 1'b1;
    #1 chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (op != 8) begin
      chk("valid_latency1", 32'(out_valid), 32'd1);
      chk($sformatf("result_op%0d", op), obs(), e);
    end else begin
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin
        chk("mul_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        n++;
      end
      chk("mul_latency", 32'(n), 32'd9);
      chk("mul_result", obs(), e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] lseq [5];
    lseq[0] = 8'h01; lseq[1] = 8'h02; lseq[2] = 8'h04; lseq[3] = 8'h08; lseq[4] = 8'h11;

    // Reset state.
    #12;
    chk("reset_outputs", obs(), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed ADD / SUB.
    do_op(0, 'hF0, 'h20);
`ifdef SAT_ARITH_EN
    chk("add_F0_20", obs(), 32'h00FF8);
`else
    chk("add_F0_20", obs(), 32'h00108);
`endif
    do_op(1, 'h05, 'h07);
`ifdef SAT_ARITH_EN
    chk("sub_05_07", obs(), 32'h0000A);
`else
    chk("sub_05_07", obs(), 32'h00FE8);
`endif
    do_op(12, 'h33, 'h44);
    chk("illegal_12", obs(), 32'h00003);
    do_op(9, 'h81, 'h03);
    chk("shl_81_3", obs(), 32'h00080);
    do_op(10, 'h81, 'h07);
    chk("shr_81_7", obs(), 32'h00010);
    in_valid = 1'b0;

    // MUL with output back-pressure.
    @(negedge clk);
    out_ready = 1'b0;
    A = 8'h0F; B = 8'h11; sel = 4'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      chk("bp_mul_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("bp_mul_latency", 32'(n), 32'd9);
    chk("bp_mul_result", obs(), 32'h00FF0);
    A = 8'h01; B = 8'h01; sel = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_result", obs(), 32'h00FF0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_drain_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_next_op_valid", 32'(out_valid), 32'd1);
    chk("bp_next_op_result", obs(), 32'h00020);
    in_valid = 1'b0;

    // LFSR sequence with ALU_Sel=7 held from reset.
    sel = 4'd7;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("lfsr_read%0d", i), obs(), 32'({8'h00, lseq[i], 4'b0000}));
      in_valid = 1'b0;
      @(negedge clk);
    end
    do_reset();
    chk("lfsr_after_reset_model", 32'(m_lfsr), 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lfsr_reset_read", obs(), 32'h00010);
    in_valid = 1'b0;

    // Counter wrap with ALU_Sel=6 held.
    sel = 4'd6;
    do_reset();
    for (int i = 0; i < 510; i++) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    chk("counter_FF", obs(), 32'h00FF0);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    chk("counter_wrap_00", obs(), 32'h00002);
    in_valid = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; sel = 4'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_result", 32'(n), 32'd0);
    chk("abort_in_ready_after", 32'(in_ready), 32'd1);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 150; i++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)));
    in_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
